// File: rtl/irq_cond_pkg.sv
// Shared constants for the interrupt conditioner: mode field width and mode encodings.
package irq_cond_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_LEVEL_HI  = 2'b00,
    MODE_LEVEL_LO  = 2'b01,
    MODE_EDGE_RISE = 2'b10,
    MODE_EDGE_FALL = 2'b11
  } irq_mode_e;

endpackage

// File: rtl/irq_cond_lane.sv
// One interrupt lane: synchroniser, glitch filter, edge latch with overflow, mode tracking.
module irq_cond_lane
  import irq_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              irq_raw_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              clr_i,
  output logic              irq_out_o,
  output logic              irq_level_o,
  output logic              overflow_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   filt_dly_q, filt_dly_d;
  logic                   latch_q, latch_d;
  logic                   ovf_q, ovf_d;
  logic                   irq_out_q, irq_out_d;
  logic [MODE_W-1:0]      mode_q;

  logic s;
  logic mode_chg;
  logic edge_hit;

  assign s        = sync_q[SYNC_STAGES-1];
  assign mode_chg = (mode_i != mode_q);

  // Next-state logic for the whole lane
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], irq_raw_i};
    filt_d     = filt_q;
    cnt_d      = cnt_q;
    filt_dly_d = filt_q;
    latch_d    = 1'b0;
    ovf_d      = 1'b0;
    irq_out_d  = 1'b0;
    edge_hit   = 1'b0;

    // Filter: s must differ from filt for more than filt_len cycles to be accepted
    if (s == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= filt_len_i) begin
      filt_d = s;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + FILT_W'(1);
    end

    if (mode_chg) begin
      // Mode switch: drop latched state, output follows the new mode next cycle
      case (mode_i)
        MODE_LEVEL_HI: irq_out_d = filt_q;
        MODE_LEVEL_LO: irq_out_d = ~filt_q;
        default:       irq_out_d = 1'b0;
      endcase
    end else if (mode_q == MODE_EDGE_RISE || mode_q == MODE_EDGE_FALL) begin
      edge_hit  = (mode_q == MODE_EDGE_FALL) ? (~filt_q & filt_dly_q)
                                             : (filt_q & ~filt_dly_q);
      latch_d   = edge_hit | (latch_q & ~clr_i);
      ovf_d     = (edge_hit & latch_q & ~clr_i) | (ovf_q & ~clr_i);
      irq_out_d = latch_d;
    end else begin
      irq_out_d = (mode_q == MODE_LEVEL_LO) ? ~filt_q : filt_q;
    end
  end

  // Lane state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      filt_q     <= 1'b0;
      cnt_q      <= '0;
      filt_dly_q <= 1'b0;
      latch_q    <= 1'b0;
      ovf_q      <= 1'b0;
      irq_out_q  <= 1'b0;
      mode_q     <= MODE_LEVEL_HI;
    end else begin
      sync_q     <= sync_d;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      filt_dly_q <= filt_dly_d;
      latch_q    <= latch_d;
      ovf_q      <= ovf_d;
      irq_out_q  <= irq_out_d;
      mode_q     <= mode_i;
    end
  end

  assign irq_out_o   = irq_out_q;
  assign irq_level_o = filt_q;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/irq_conditioner.sv
// Interrupt conditioner: NUM_IRQS independent lanes sharing a global filter length.
module irq_conditioner
  import irq_cond_pkg::*;
#(
  parameter int unsigned NUM_IRQS    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IRQS-1:0]        irq_raw,
  input  logic [MODE_W*NUM_IRQS-1:0] mode,
  input  logic [FILT_W-1:0]          filt_len,
  input  logic [NUM_IRQS-1:0]        clr,
  output logic [NUM_IRQS-1:0]        irq_out,
  output logic [NUM_IRQS-1:0]        irq_level,
  output logic [NUM_IRQS-1:0]        overflow
);

  // One conditioning lane per source
  for (genvar gi = 0; gi < NUM_IRQS; gi++) begin : g_lane
    irq_cond_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_raw_i   (irq_raw[gi]),
      .mode_i      (mode[MODE_W*gi +: MODE_W]),
      .filt_len_i  (filt_len),
      .clr_i       (clr[gi]),
      .irq_out_o   (irq_out[gi]),
      .irq_level_o (irq_level[gi]),
      .overflow_o  (overflow[gi])
    );
  end

endmodule

// File: tb/tb_irq_conditioner.sv
// Bench for irq_conditioner: directed scenarios plus randomized run against a reference model.
module tb_irq_conditioner;

  localparam int unsigned N = 16;
  localparam int unsigned S = 2;
  localparam int unsigned W = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   irq_raw;
  logic [2*N-1:0] mode;
  logic [W-1:0]   filt_len;
  logic [N-1:0]   clr;
  logic [N-1:0]   irq_out;
  logic [N-1:0]   irq_level;
  logic [N-1:0]   overflow;

  int checks;
  int failures;

  irq_conditioner #(.NUM_IRQS(N), .SYNC_STAGES(S), .FILT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_raw   (irq_raw),
    .mode      (mode),
    .filt_len  (filt_len),
    .clr       (clr),
    .irq_out   (irq_out),
    .irq_level (irq_level),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw history gives the synchronised value; a qualification
  // run length decides when the filtered level accepts a new value.
  logic [N-1:0] hist [S];
  logic [N-1:0] m_filt, m_prev, m_latch, m_ovf, m_out;
  int           m_run [N];
  logic [2*N-1:0] m_mode;
  logic ms, mf, mp, ev;
  logic [1:0] om, nm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) hist[k] = '0;
      m_filt = '0; m_prev = '0; m_latch = '0; m_ovf = '0; m_out = '0; m_mode = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        ms = hist[S-1][i];
        mf = m_filt[i];
        mp = m_prev[i];
        om = m_mode[2*i +: 2];
        nm = mode[2*i +: 2];
        if (ms == mf) m_run[i] = 0;
        else if (m_run[i] + 1 > int'(filt_len)) begin m_filt[i] = ms; m_run[i] = 0; end
        else m_run[i] = m_run[i] + 1;
        if (nm != om) begin
          m_latch[i] = 1'b0;
          m_ovf[i]   = 1'b0;
          m_out[i]   = (nm == 2'b00) ? mf : (nm == 2'b01) ? !mf : 1'b0;
        end else if (om == 2'b10 || om == 2'b11) begin
          ev = (om == 2'b10) ? (mf && !mp) : (!mf && mp);
          if (clr[i]) begin
            m_ovf[i]   = 1'b0;
            m_latch[i] = ev;
          end else begin
            if (ev && m_latch[i]) m_ovf[i] = 1'b1;
            if (ev) m_latch[i] = 1'b1;
          end
          m_out[i] = m_latch[i];
        end else begin
          m_latch[i] = 1'b0;
          m_ovf[i]   = 1'b0;
          m_out[i]   = (om == 2'b01) ? !mf : mf;
        end
        m_prev[i] = mf;
      end
      for (int k = S - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = irq_raw;
      m_mode  = mode;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; irq_raw = '0; mode = '0; filt_len = '0; clr = '0;
    tick(2);
    checks++; if (irq_out !== '0) begin failures++; $display("FAIL reset_irq_out got=%h exp=0", irq_out); end
    checks++; if (overflow !== '0) begin failures++; $display("FAIL reset_overflow got=%h exp=0", overflow); end
    checks++; if (irq_level !== '0) begin failures++; $display("FAIL reset_irq_level got=%h exp=0", irq_level); end
    rst_n = 1'b1;
    tick(3);
    checks++; if (irq_out !== '0) begin failures++; $display("FAIL post_reset_irq_out got=%h exp=0", irq_out); end
  endtask

  task automatic test_level_hi;
    filt_len = '0;
    irq_raw[3] = 1'b1;
    tick(3);
    checks++; if (irq_out[3] !== 1'b0) begin failures++; $display("FAIL lvl_rise_e3 got=%b exp=0", irq_out[3]); end
    checks++; if (irq_level[3] !== 1'b1) begin failures++; $display("FAIL lvl_level_e3 got=%b exp=1", irq_level[3]); end
    tick(1);
    checks++; if (irq_out[3] !== 1'b1) begin failures++; $display("FAIL lvl_rise_e4 got=%b exp=1", irq_out[3]); end
    irq_raw[3] = 1'b0;
    tick(3);
    checks++; if (irq_out[3] !== 1'b1) begin failures++; $display("FAIL lvl_fall_e3 got=%b exp=1", irq_out[3]); end
    tick(1);
    checks++; if (irq_out[3] !== 1'b0) begin failures++; $display("FAIL lvl_fall_e4 got=%b exp=0", irq_out[3]); end
  endtask

  task automatic test_glitch;
    logic seen;
    filt_len = W'(3);
    tick(4);
    irq_raw[0] = 1'b1;
    tick(3);
    irq_raw[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (irq_out[0] !== 1'b0) seen = 1'b1;
      tick(1);
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL glitch_3cyc got=1 exp=0"); end
    irq_raw[0] = 1'b1;
    tick(4);
    irq_raw[0] = 1'b0;
    tick(2);
    checks++; if (irq_out[0] !== 1'b0) begin failures++; $display("FAIL glitch_4cyc_e6 got=%b exp=0", irq_out[0]); end
    tick(1);
    checks++; if (irq_out[0] !== 1'b1) begin failures++; $display("FAIL glitch_4cyc_e7 got=%b exp=1", irq_out[0]); end
    tick(12);
    filt_len = '0;
  endtask

  task automatic test_edge_latch;
    mode[11:10] = 2'b10;
    tick(2);
    irq_raw[5] = 1'b1;
    tick(4);
    checks++; if (irq_out[5] !== 1'b1) begin failures++; $display("FAIL edge_set got=%b exp=1", irq_out[5]); end
    irq_raw[5] = 1'b0;
    tick(6);
    checks++; if (irq_out[5] !== 1'b1) begin failures++; $display("FAIL edge_hold got=%b exp=1", irq_out[5]); end
    checks++; if (overflow[5] !== 1'b0) begin failures++; $display("FAIL edge_no_ovf got=%b exp=0", overflow[5]); end
    clr[5] = 1'b1;
    tick(1);
    clr[5] = 1'b0;
    checks++; if (irq_out[5] !== 1'b0) begin failures++; $display("FAIL edge_clr got=%b exp=0", irq_out[5]); end
  endtask

  task automatic test_overflow_race;
    irq_raw[5] = 1'b1; tick(4);
    irq_raw[5] = 1'b0; tick(5);
    irq_raw[5] = 1'b1; tick(4);
    checks++; if (overflow[5] !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow[5]); end
    checks++; if (irq_out[5] !== 1'b1) begin failures++; $display("FAIL ovf_latch got=%b exp=1", irq_out[5]); end
    irq_raw[5] = 1'b0; tick(5);
    clr[5] = 1'b1; tick(1); clr[5] = 1'b0;
    checks++; if ({irq_out[5], overflow[5]} !== 2'b00) begin failures++; $display("FAIL ovf_clr got=%b exp=00", {irq_out[5], overflow[5]}); end
    irq_raw[5] = 1'b1; tick(4);
    irq_raw[5] = 1'b0; tick(5);
    irq_raw[5] = 1'b1; tick(3);
    clr[5] = 1'b1; tick(1); clr[5] = 1'b0;
    checks++; if (irq_out[5] !== 1'b1) begin failures++; $display("FAIL race_latch got=%b exp=1", irq_out[5]); end
    checks++; if (overflow[5] !== 1'b0) begin failures++; $display("FAIL race_ovf got=%b exp=0", overflow[5]); end
    irq_raw[5] = 1'b0; tick(5);
    clr[5] = 1'b1; tick(1); clr[5] = 1'b0;
  endtask

  task automatic test_mode_change;
    logic seen;
    irq_raw[2] = 1'b1;
    tick(5);
    checks++; if (irq_out[2] !== 1'b1) begin failures++; $display("FAIL mc_lvl_hi got=%b exp=1", irq_out[2]); end
    mode[5:4] = 2'b10;
    tick(1);
    checks++; if (irq_out[2] !== 1'b0) begin failures++; $display("FAIL mc_to_edge got=%b exp=0", irq_out[2]); end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      if (irq_out[2] !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mc_spurious got=1 exp=0"); end
    mode[5:4] = 2'b01;
    tick(1);
    checks++; if (irq_out[2] !== 1'b0) begin failures++; $display("FAIL mc_to_lvl_lo got=%b exp=0", irq_out[2]); end
    irq_raw[2] = 1'b0;
    tick(4);
    checks++; if (irq_out[2] !== 1'b1) begin failures++; $display("FAIL mc_lvl_lo_low got=%b exp=1", irq_out[2]); end
    mode[5:4] = 2'b00;
    tick(3);
  endtask

  task automatic test_reset_mid;
    logic bad;
    mode[15:14] = 2'b10;
    tick(2);
    irq_raw[5] = 1'b1; irq_raw[7] = 1'b1; tick(4);
    irq_raw[5] = 1'b0; irq_raw[7] = 1'b0; tick(4);
    irq_raw[5] = 1'b1; irq_raw[7] = 1'b1; tick(4);
    checks++; if ({overflow[7], overflow[5]} !== 2'b11) begin failures++; $display("FAIL rm_pre_ovf got=%b exp=11", {overflow[7], overflow[5]}); end
    irq_raw = 16'h0200;
    tick(5);
    checks++; if (irq_out !== 16'h02A0) begin failures++; $display("FAIL rm_pre_out got=%h exp=02a0", irq_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({irq_out, overflow, irq_level} !== '0) begin failures++; $display("FAIL rm_async got=%h/%h/%h exp=0", irq_out, overflow, irq_level); end
    #1 rst_n = 1'b1;
    tick(1);
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (irq_out !== '0 || overflow !== '0) bad = 1'b1;
      tick(1);
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rm_hold got=1 exp=0"); end
    checks++; if (irq_out !== 16'h0200) begin failures++; $display("FAIL rm_requal got=%h exp=0200", irq_out); end
  endtask

  task automatic test_random;
    for (int i = 0; i < int'(N); i++) mode[2*i +: 2] = 2'($urandom);
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 0) filt_len = W'($urandom_range(0, 5));
      for (int i = 0; i < int'(N); i++)
        if ($urandom_range(0, 7) == 0) irq_raw[i] = ~irq_raw[i];
      clr = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        int l;
        l = $urandom_range(0, N - 1);
        mode[2*l +: 2] = 2'($urandom);
      end
      tick(1);
      checks++; if (irq_out !== m_out) begin failures++; $display("FAIL rnd_irq_out cyc=%0d got=%h exp=%h", c, irq_out, m_out); end
      checks++; if (irq_level !== m_filt) begin failures++; $display("FAIL rnd_irq_level cyc=%0d got=%h exp=%h", c, irq_level, m_filt); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow cyc=%0d got=%h exp=%h", c, overflow, m_ovf); end
    end
    clr = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    irq_raw = '0; mode = '0; filt_len = '0; clr = '0;
    test_reset();
    test_level_hi();
    test_glitch();
    test_edge_latch();
    test_overflow_race();
    test_mode_change();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
